fifo_hsk_param: RTL and testbench
=================================

Name: fifo_hsk_param

Overview:
Parametrised successor to the team's req/ack FIFO. Single-clock synchronous FIFO with push and pop req/ack handshakes on both sides.
- Adds: arbitrary (non-power-of-2) DEPTH, occupancy count output, programmable almost-full/almost-empty flags, synchronous flush.
- Sits between a producer and a consumer datapath; the existing fifo_sva checker binds to its core ports unchanged.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 12, number of entries (>=2, need not be a power of 2)
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
push_req  in  1  producer request; held with data_in stable until push_ack
data_in  in  WIDTH  write data
push_ack  out  1  write accepted this cycle
pop_req  in  1  consumer request; held until pop_ack
pop_ack  out  1  read accepted this cycle
data_out  out  WIDTH  read data, valid the cycle after pop handshake
flush  in  1  synchronous clear of contents
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  CW  occupancy, CW = $clog2(DEPTH+1)

Behaviour:
- Reset (async assert, sync-clean deassert): wr_ptr=0, rd_ptr=0, count=0, data_out=0, empty=1, full=0, almost_empty=1, almost_full=0.
- push_ack = push_req && !full && !flush. pop_ack = pop_req && !empty && !flush. Both are combinational from registered state plus inputs; they do not depend on the other side's handshake in the same cycle.
- push_hsk = push_req && push_ack; pop_hsk likewise.
- push_hsk: mem[wr_ptr] <= data_in; wr_ptr advances.
- pop_hsk: data_out <= mem[rd_ptr] on the same edge, so data_out is valid the cycle after the handshake (latency 1); rd_ptr advances.
- data_out holds its value when there is no pop_hsk.
- Pointer width PW = max(1,$clog2(DEPTH)). Pointers wrap explicitly from DEPTH-1 to 0; modulo-2^PW wrap is not allowed.
- count_nxt = count + push_hsk - pop_hsk, computed in CW bits; it never over- or underflows because of the ack gating.
- Simultaneous push_hsk and pop_hsk (0<count<DEPTH): count unchanged, both pointers advance.
- Full: no push_ack, even when a pop occurs in the same cycle. Empty: no pop_ack (unless the optional feature is enabled).
- All flags decode directly from registered count: full/empty/almost flags update the cycle after the count change.
- flush=1: acks forced 0. Next edge: wr_ptr=rd_ptr=count=0, so empty=1. data_out is not cleared; mem contents are don't-care. flush overrides any push/pop request in the same cycle.
- Reset mid-transfer: all state returns to reset values immediately; in-flight requests are dropped. Producer and consumer must re-present them.
- Elaboration-time errors: DEPTH<2, AF_THRESH outside 1..DEPTH, AE_THRESH outside 0..DEPTH-1.

Optional Feature:
FIFO_HSK_BYPASS_EN
- Defined: when empty && push_hsk && pop_req && !flush, pop_ack=1 and the word bypasses storage. data_out <= data_in next edge; count stays 0; pointers do not move. Gives 1-cycle cut-through latency from an empty FIFO. The fifo_sva rule "empty |-> !pop_ack" must then be qualified with !push_hsk.
- Undefined: behaviour exactly as above; first data out is no earlier than 2 cycles after push.

Decomposition:
- Package fifo_hsk_pkg: function ptr_w(depth) and cnt_w(depth) (clog2 helpers with min 1), function ptr_inc(ptr, depth) with explicit wrap.
- One sub-module fifo_hsk_mem: WIDTH x DEPTH register array with write port (we, waddr, wdata) and read port (raddr, rdata, combinational). The top holds pointers, count, flags, handshake and the data_out register.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 with no pop -> count=3, empty 1->0 after the first push. Pop x3 -> data_out=0x11,0x22,0x33, each 1 cycle after its pop_ack.
2. DEPTH=12: push 12 words -> full=1 at count 12; 13th push_req gets push_ack=0 and is held. One pop -> held push acked next cycle, count returns to 12.
3. Wrap: 30 push/pop pairs interleaved at steady count 5 -> data order preserved across pointer wrap 11->0; count stays 5.
4. Simultaneous push and pop at count=4 -> count stays 4, both acks=1. At count=0 with a push and a pop_req -> pop_ack=0 (bypass off), count becomes 1.
5. AF_THRESH=10, AE_THRESH=1: fill 0->10 -> almost_empty drops when count reaches 2, almost_full rises at count 10. Flush at count 7 with push_req high -> push_ack=0, next cycle count=0, empty=1.
6. FIFO_HSK_BYPASS_EN defined: empty, push 0xA5 with pop_req -> both acks=1, next cycle data_out=0xA5, count=0.

Source files
------------

// File: rtl/fifo_hsk_pkg.sv
// Shared helpers for the parametrised req/ack FIFO: pointer/count widths
// and the explicit non-power-of-2 pointer wrap.
package fifo_hsk_pkg;

    localparam int MIN_DEPTH = 2;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Wraps at depth-1 rather than at 2^PW so odd depths never touch dead slots.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_hsk_mem.sv
// WIDTH x DEPTH storage array for fifo_hsk_param: one synchronous write
// port and one combinational read port.
module fifo_hsk_mem
    import fifo_hsk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_hsk_param.sv
// Single-clock req/ack FIFO with arbitrary DEPTH, occupancy count, almost
// flags and synchronous flush. Define FIFO_HSK_BYPASS_EN for empty cut-through.
module fifo_hsk_param
    import fifo_hsk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 12,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push_req,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    push_ack,
    input  logic                    pop_req,
    output logic                    pop_ack,
    output logic [WIDTH-1:0]        data_out,
    input  logic                    flush,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [cnt_w(DEPTH)-1:0] count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < MIN_DEPTH) begin : g_depth_chk
        $error("fifo_hsk_param: DEPTH (%0d) must be >= 2", DEPTH);
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_chk
        $error("fifo_hsk_param: AF_THRESH (%0d) must be in 1..DEPTH", AF_THRESH);
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_ae_chk
        $error("fifo_hsk_param: AE_THRESH (%0d) must be in 0..DEPTH-1", AE_THRESH);
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_word;
    logic             push_hsk;
    logic             pop_hsk;
    logic             bypass;
    logic             mem_we;
    logic [CW-1:0]    count_nxt;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign push_ack = push_req && !full && !flush;
    assign push_hsk = push_req && push_ack;

`ifdef FIFO_HSK_BYPASS_EN
    assign bypass = empty && push_hsk && pop_req && !flush;
`else
    assign bypass = 1'b0;
`endif

    // The pop side may look at push_hsk, but never the reverse, so no loop.
    assign pop_ack = pop_req && !flush && (!empty || bypass);
    assign pop_hsk = pop_req && pop_ack;

    assign mem_we    = push_hsk && !bypass;
    assign count_nxt = count + CW'(mem_we) - CW'(pop_hsk && !bypass);

    fifo_hsk_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (mem_we) begin
                wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (bypass) begin
                data_out <= data_in;
            end else if (pop_hsk) begin
                data_out <= rd_word;
                rd_ptr   <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
            end
        end
    end

endmodule

// File: tb/tb_fifo_hsk_param.sv
// Directed self-checking bench for fifo_hsk_param at DEPTH=12, AF=10, AE=1.
// Bypass checks switch on with FIFO_HSK_BYPASS_EN.
module tb_fifo_hsk_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 12;
    localparam int AF    = 10;
    localparam int AE    = 1;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             push_req = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             push_ack;
    logic             pop_req = 1'b0;
    logic             pop_ack;
    logic [WIDTH-1:0] data_out;
    logic             flush = 1'b0;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;

    int   vectors = 0;
    int   miscompares = 0;
    logic pa;
    logic qa;

    fifo_hsk_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .push_req     (push_req),
        .data_in      (data_in),
        .push_ack     (push_ack),
        .pop_req      (pop_req),
        .pop_ack      (pop_ack),
        .data_out     (data_out),
        .flush        (flush),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one cycle of inputs, captures the acks just before the edge,
    // then returns 1 time unit after the edge so registered state is settled.
    task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic q,
                        input logic f, output logic pa_o, output logic qa_o);
        push_req = p;
        data_in  = d;
        pop_req  = q;
        flush    = f;
        #1;
        pa_o = push_ack;
        qa_o = pop_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ae: got %b expected 1", almost_empty); end
        vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_af: got %b expected 0", almost_full); end
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_dout: got %h expected 00", data_out); end
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b = '{8'h11, 8'h22, 8'h33};
        step(1'b1, 8'h11, 1'b0, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_push_ack: got %b expected 1", pa); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_empty_drop: got %b expected 0", empty); end
        step(1'b1, 8'h22, 1'b0, 1'b0, pa, qa);
        step(1'b1, 8'h33, 1'b0, 1'b0, pa, qa);
        vectors++; if (count !== 4'd3) begin miscompares++; $display("[TB] FAIL basic_count3: got %0d expected 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
            vectors++; if (qa !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_pop_ack[%0d]: got %b expected 1", i, qa); end
            vectors++; if (data_out !== exp_b[i]) begin miscompares++; $display("[TB] FAIL basic_dout[%0d]: got %h expected %h", i, data_out, exp_b[i]); end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, pa, qa);
        vectors++; if (data_out !== 8'h33) begin miscompares++; $display("[TB] FAIL basic_dout_hold: got %h expected 33", data_out); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_empty_end: got %b expected 1", empty); end
    endtask

    task automatic test_full();
        logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, pa, qa);
        end
        vectors++; if (count !== 4'd12) begin miscompares++; $display("[TB] FAIL full_count12: got %0d expected 12", count); end
        vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL full_flag: got %b expected 1", full); end
        step(1'b1, 8'h99, 1'b0, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b0) begin miscompares++; $display("[TB] FAIL full_push_blocked: got %b expected 0", pa); end
        vectors++; if (count !== 4'd12) begin miscompares++; $display("[TB] FAIL full_count_held: got %0d expected 12", count); end
        step(1'b1, 8'h99, 1'b1, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b0) begin miscompares++; $display("[TB] FAIL full_push_with_pop: got %b expected 0", pa); end
        vectors++; if (qa !== 1'b1) begin miscompares++; $display("[TB] FAIL full_pop_ack: got %b expected 1", qa); end
        vectors++; if (count !== 4'd11) begin miscompares++; $display("[TB] FAIL full_count11: got %0d expected 11", count); end
        step(1'b1, 8'h99, 1'b0, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b1) begin miscompares++; $display("[TB] FAIL full_held_push_ack: got %b expected 1", pa); end
        vectors++; if (count !== 4'd12) begin miscompares++; $display("[TB] FAIL full_count_back12: got %0d expected 12", count); end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
            e = (i < DEPTH - 1) ? 8'(8'h41 + i) : 8'h99;
            vectors++; if (data_out !== e) begin miscompares++; $display("[TB] FAIL full_drain[%0d]: got %h expected %h", i, data_out, e); end
        end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL full_drained_empty: got %b expected 1", empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        logic [7:0] nxt;
        logic [7:0] e;
        nxt = 8'h60;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, nxt, 1'b0, 1'b0, pa, qa);
            q.push_back(nxt);
            nxt++;
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, nxt, 1'b1, 1'b0, pa, qa);
            q.push_back(nxt);
            nxt++;
            e = q.pop_front();
            vectors++; if (data_out !== e) begin miscompares++; $display("[TB] FAIL wrap_dout[%0d]: got %h expected %h", i, data_out, e); end
            vectors++; if (count !== 4'd5) begin miscompares++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected 5", i, count); end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
            e = q.pop_front();
            vectors++; if (data_out !== e) begin miscompares++; $display("[TB] FAIL wrap_drain[%0d]: got %h expected %h", i, data_out, e); end
        end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL wrap_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, pa, qa);
        end
        step(1'b1, 8'hB4, 1'b1, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_push_ack: got %b expected 1", pa); end
        vectors++; if (qa !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_pop_ack: got %b expected 1", qa); end
        vectors++; if (count !== 4'd4) begin miscompares++; $display("[TB] FAIL simul_count4: got %0d expected 4", count); end
        vectors++; if (data_out !== 8'hB0) begin miscompares++; $display("[TB] FAIL simul_dout: got %h expected b0", data_out); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
            vectors++; if (data_out !== 8'(8'hB1 + i)) begin miscompares++; $display("[TB] FAIL simul_drain[%0d]: got %h expected %h", i, data_out, 8'(8'hB1 + i)); end
        end
        step(1'b1, 8'h5A, 1'b1, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_empty_push_ack: got %b expected 1", pa); end
`ifdef FIFO_HSK_BYPASS_EN
        vectors++; if (qa !== 1'b1) begin miscompares++; $display("[TB] FAIL simul_empty_pop_ack: got %b expected 1", qa); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL simul_empty_count: got %0d expected 0", count); end
        vectors++; if (data_out !== 8'h5A) begin miscompares++; $display("[TB] FAIL simul_empty_dout: got %h expected 5a", data_out); end
`else
        vectors++; if (qa !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_empty_pop_ack: got %b expected 0", qa); end
        vectors++; if (count !== 4'd1) begin miscompares++; $display("[TB] FAIL simul_empty_count: got %0d expected 1", count); end
        step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
        vectors++; if (data_out !== 8'h5A) begin miscompares++; $display("[TB] FAIL simul_empty_dout: got %h expected 5a", data_out); end
`endif
    endtask

    task automatic test_flags_flush();
        for (int i = 1; i <= AF; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, pa, qa);
            vectors++; if (almost_empty !== logic'(i <= AE)) begin miscompares++; $display("[TB] FAIL flags_ae[%0d]: got %b expected %b", i, almost_empty, logic'(i <= AE)); end
            vectors++; if (almost_full !== logic'(i >= AF)) begin miscompares++; $display("[TB] FAIL flags_af[%0d]: got %b expected %b", i, almost_full, logic'(i >= AF)); end
        end
        vectors++; if (count !== 4'd10) begin miscompares++; $display("[TB] FAIL flags_count10: got %0d expected 10", count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
        end
        vectors++; if (data_out !== 8'h03) begin miscompares++; $display("[TB] FAIL flags_pop3: got %h expected 03", data_out); end
        vectors++; if (count !== 4'd7) begin miscompares++; $display("[TB] FAIL flags_count7: got %0d expected 7", count); end
        step(1'b1, 8'h77, 1'b1, 1'b1, pa, qa);
        vectors++; if (pa !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_push_ack: got %b expected 0", pa); end
        vectors++; if (qa !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_pop_ack: got %b expected 0", qa); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_empty: got %b expected 1", empty); end
        vectors++; if (data_out !== 8'h03) begin miscompares++; $display("[TB] FAIL flush_dout_kept: got %h expected 03", data_out); end
        step(1'b1, 8'hC3, 1'b0, 1'b0, pa, qa);
        step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
        vectors++; if (data_out !== 8'hC3) begin miscompares++; $display("[TB] FAIL flush_then_fifo: got %h expected c3", data_out); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hD1, 1'b0, 1'b0, pa, qa);
        step(1'b1, 8'hD2, 1'b0, 1'b0, pa, qa);
        push_req = 1'b1;
        data_in  = 8'hD3;
        #2;
        resetn = 1'b0;
        #1;
        vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL rstmid_count: got %0d expected 0", count); end
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("[TB] FAIL rstmid_dout: got %h expected 00", data_out); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_empty: got %b expected 1", empty); end
        push_req = 1'b0;
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'hE1, 1'b0, 1'b0, pa, qa);
        step(1'b0, 8'h00, 1'b1, 1'b0, pa, qa);
        vectors++; if (data_out !== 8'hE1) begin miscompares++; $display("[TB] FAIL rstmid_after: got %h expected e1", data_out); end
    endtask

`ifdef FIFO_HSK_BYPASS_EN
    task automatic test_bypass();
        step(1'b1, 8'hA5, 1'b1, 1'b0, pa, qa);
        vectors++; if (pa !== 1'b1) begin miscompares++; $display("[TB] FAIL bypass_push_ack: got %b expected 1", pa); end
        vectors++; if (qa !== 1'b1) begin miscompares++; $display("[TB] FAIL bypass_pop_ack: got %b expected 1", qa); end
        vectors++; if (data_out !== 8'hA5) begin miscompares++; $display("[TB] FAIL bypass_dout: got %h expected a5", data_out); end
        vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL bypass_count: got %0d expected 0", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_simultaneous();
        test_flags_flush();
        test_reset_mid();
`ifdef FIFO_HSK_BYPASS_EN
        test_bypass();
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0, pa, qa);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
